// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package kgp_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_DISCARD    = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int          DEFAULT_BUF_DEPTH = 2;
    localparam logic [31:0] PC_INCR           = 32'd4;
    localparam int          ENTRY_W           = 64;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of {pc, instr} pairs; flush wins over push/pop.
module fetch_fifo
    import kgp_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] data,
    output logic [1:0]         count,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] slots [2];
    logic               wr_ptr;
    logic               rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, two-entry buffer
// towards the core, redirect with in-flight response discard.
module instr_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

    fetch_state_t state, next_state;
    logic [31:0]  req_addr, next_addr;
    logic [31:0]  pend_pc, next_pend;
    logic         started;
    logic         push, pop, flush;
    logic [1:0]   count, count_after;
    logic [63:0]  head;
    logic [31:0]  target;

    // Core handshake: an entry transfers on a cycle where instr_valid and
    // instr_ready are both high; instr_valid never drops without a pop or flush.
    assign instr_valid = (count != 2'd0);
    assign instruction = instr_valid ? head[31:0]  : 32'h0;
    assign instr_pc    = instr_valid ? head[63:32] : 32'h0;
    assign imem_addr   = req_addr;
    // started stays low for the first cycle after reset so a stale ack is ignored.
    assign imem_req    = started && (state != ST_WAIT_SPACE);
    assign fsm_state   = state;

    assign target      = align_pc(redirect_pc);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign flush       = redirect;
    assign count_after = count + 2'd1 - {1'b0, pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FETCH;
            req_addr <= RESET_PC;
            pend_pc  <= RESET_PC;
            started  <= 1'b0;
        end else begin
            state    <= next_state;
            req_addr <= next_addr;
            pend_pc  <= next_pend;
            started  <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_addr  = req_addr;
        next_pend  = pend_pc;
        push       = 1'b0;
        case (state)
            ST_FETCH: begin
                if (!started) begin
                    if (redirect) next_addr = target;
                end else if (redirect) begin
                    if (imem_ack) begin
                        next_addr = target;
                    end else begin
                        next_state = ST_DISCARD;
                        next_pend  = target;
                    end
                end else if (imem_ack) begin
                    push      = 1'b1;
                    next_addr = req_addr + PC_INCR;
                    if (count_after == FULL_COUNT) next_state = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (redirect) begin
                    next_addr  = target;
                    next_state = ST_FETCH;
                end else if (pop) begin
                    next_state = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // The old address stays on the bus until its response is dropped.
                if (imem_ack) begin
                    next_addr  = redirect ? target : pend_pc;
                    next_state = ST_FETCH;
                end else if (redirect) begin
                    next_pend = target;
                end
            end
            default: next_state = ST_FETCH;
        endcase
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .data  ({req_addr, imem_rdata}),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_instr_fetch_unit;
    import kgp_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack, ack2;
    logic [31:0] rdata;
    logic        redirect, redirect2;
    logic [31:0] redirect_pc;
    logic        ready, ready2;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instruction, instruction2;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr_pc, instr_pc2;
    logic [1:0]  fsm_state, fsm_state2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(ack), .imem_rdata(rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_ready(ready), .instruction(instruction),
        .instr_valid(instr_valid), .instr_pc(instr_pc), .fsm_state(fsm_state)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(ack2), .imem_rdata(rdata), .redirect(redirect2),
        .redirect_pc(redirect_pc), .instr_ready(ready2), .instruction(instruction2),
        .instr_valid(instr_valid2), .instr_pc(instr_pc2), .fsm_state(fsm_state2)
    );

    // Reference model: queue of {pc, instr}, current fetch address, fetch mode.
    localparam int M_FETCH = 0;
    localparam int M_WAIT  = 1;
    localparam int M_DISC  = 2;
    logic [63:0] exp_q[$];
    logic        m_armed = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_pend  = 32'h0;
    int          m_mode  = M_FETCH;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        logic [31:0] tgt;
        logic        popping;
        @(posedge clk or negedge rst);
        if (!rst) begin
            exp_q.delete();
            m_armed = 1'b0;
            m_addr  = 32'h0;
            m_pend  = 32'h0;
            m_mode  = M_FETCH;
        end else if (!m_armed) begin
            m_armed = 1'b1;
            if (redirect) m_addr = {redirect_pc[31:2], 2'b00};
        end else begin
            tgt     = {redirect_pc[31:2], 2'b00};
            popping = (exp_q.size() > 0) && ready && !redirect;
            if (redirect) begin
                exp_q.delete();
                if (m_mode == M_WAIT || (m_mode != M_WAIT && ack)) begin
                    m_addr = tgt;
                    m_mode = M_FETCH;
                end else begin
                    m_pend = tgt;
                    m_mode = M_DISC;
                end
            end else begin
                if (popping) void'(exp_q.pop_front());
                if (m_mode == M_FETCH && ack) begin
                    exp_q.push_back({m_addr, rdata});
                    m_addr = m_addr + 32'd4;
                    if (exp_q.size() == 2) m_mode = M_WAIT;
                end else if (m_mode == M_WAIT && popping) begin
                    m_mode = M_FETCH;
                end else if (m_mode == M_DISC && ack) begin
                    m_addr = m_pend;
                    m_mode = M_FETCH;
                end
            end
        end
    end

    initial forever begin
        logic        ev;
        logic [63:0] hd;
        @(negedge clk);
        ev = (exp_q.size() > 0);
        hd = ev ? exp_q[0] : 64'h0;
        check("imem_req",    32'(imem_req),    32'(m_armed && m_mode != M_WAIT));
        check("imem_addr",   imem_addr,        m_addr);
        check("instr_valid", 32'(instr_valid), 32'(ev));
        check("instruction", instruction,      hd[31:0]);
        check("instr_pc",    instr_pc,         hd[63:32]);
    end

    task automatic drive(input logic a, input logic r, input logic rd, input logic [31:0] rpc);
        ack         = a;
        ready       = r;
        redirect    = rd;
        redirect_pc = rpc;
        rdata       = {16'hC0DE, imem_addr[15:0]};
        @(posedge clk);
        #1;
        ack      = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ack = 1'b0; ack2 = 1'b0; rdata = 32'h0; redirect = 1'b0;
        redirect2 = 1'b0; redirect_pc = 32'h0; ready = 1'b0; ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",   32'(imem_req),  32'h0);
        check("rst_addr",  imem_addr,      32'h0);
        check("rst_instr", instruction,    32'h0);
        check("rst_addr2", imem_addr2,     32'hFFFF_FFFC);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_req",  32'(imem_req),  32'h1);
        check("first_req2", 32'(imem_req2), 32'h1);

        // Streaming fetch with the core always ready
        ack2 = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        ack2 = 1'b0;
        check("a_pc0",     instr_pc,      32'h0);
        check("a_ins0",    instruction,   32'hC0DE_0000);
        check("a_addr4",   imem_addr,     32'h4);
        check("wrap_addr", imem_addr2,    32'h0);
        check("wrap_pc",   instr_pc2,     32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("a_pc12",    instr_pc,      32'hC);
        check("a_addr16",  imem_addr,     32'h10);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("a_drain",   32'(instr_valid), 32'h0);

        // Buffer fills, fetch stalls, one pop resumes in order
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("b_req0",    32'(imem_req),  32'h0);
        check("b_state",   32'(fsm_state), 32'(ST_WAIT_SPACE));
        check("b_addr",    imem_addr,      32'h18);
        check("b_pc16",    instr_pc,       32'h10);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("b_req1",    32'(imem_req),  32'h1);
        check("b_pc20",    instr_pc,       32'h14);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("b_pc24",    instr_pc,       32'h18);
        check("b_ins24",   instruction,    32'hC0DE_0018);
        drive(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect with request outstanding: discard old response
        drive(1'b0, 1'b1, 1'b1, 32'h203);
        check("c_state",   32'(fsm_state), 32'(ST_DISCARD));
        check("c_hold",    imem_addr,      32'h1C);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("c_hold2",   imem_addr,      32'h1C);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("c_new",     imem_addr,      32'h200);
        check("c_drop",    32'(instr_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h305);
        drive(1'b0, 1'b1, 1'b1, 32'h401);
        check("c2_hold",   imem_addr,      32'h200);
        drive(1'b1, 1'b1, 1'b1, 32'h500);
        check("c2_new",    imem_addr,      32'h500);

        // Redirect coincident with ack, and redirect from a full buffer
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("d_pc500",   instr_pc,       32'h500);
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        check("d_flush",   32'(instr_valid), 32'h0);
        check("d_addr",    imem_addr,      32'h40);
        check("d_pc0",     instr_pc,       32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("d_pc40",    instr_pc,       32'h40);
        check("d_ins40",   instruction,    32'hC0DE_0040);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("d_full",    32'(fsm_state), 32'(ST_WAIT_SPACE));
        drive(1'b0, 1'b0, 1'b1, 32'h80);
        check("d_waddr",   imem_addr,      32'h80);
        check("d_wreq",    32'(imem_req),  32'h1);

        // Reset mid-request, stray ack after release
        rst = 1'b0;
        #2;
        check("e_req",     32'(imem_req),  32'h0);
        check("e_addr",    imem_addr,      32'h0);
        check("e_valid",   32'(instr_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("e_stray",   32'(instr_valid), 32'h0);
        check("e_restart", imem_addr,      32'h0);
        check("e_req1",    32'(imem_req),  32'h1);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("e_pc0",     instr_pc,       32'h0);
        check("e_addr4",   imem_addr,      32'h4);
        drive(1'b0, 1'b1, 1'b0, 32'h0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
